// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the cache fill sequencer.
//
// Contents:
//   fill_state_t     - sequencer state encoding
//   WORDS_PER_BLOCK  - 16-bit words per cache block (16-byte block)
//   BLOCK_OFFSET_W   - width of the word index within a block
//   ADDR_W / DATA_W  - memory address and data widths
//   BLOCK_MASK       - clears the byte offset to give a block base address
//   block_word_addr  - byte address of word 'word' inside the block holding 'addr'
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_D,
        FILL_I
    } fill_state_t;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 3;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    // Word offsets stay inside the block: the 3-bit index wraps and never
    // carries into the block base.
    function automatic logic [ADDR_W-1:0] block_word_addr(
        input logic [ADDR_W-1:0]         addr,
        input logic [BLOCK_OFFSET_W-1:0] word
    );
        return (addr & BLOCK_MASK) | {12'd0, word, 1'b0};
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for one direction (issue or receive) of a block fill.
//
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_load        - start a new block; captures i_start as the first word
//   i_start       - first word index of the block transfer
//   i_inc         - one word transferred this cycle (also honoured with i_load)
//   o_word        - word index of the current transfer, wraps modulo 8
//   o_done        - current transfer is the 8th of the block
module fill_word_counter
    import cache_fill_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic [BLOCK_OFFSET_W-1:0] i_start,
    input  logic                      i_inc,
    output logic [BLOCK_OFFSET_W-1:0] o_word,
    output logic                      o_done
);

    logic [BLOCK_OFFSET_W-1:0] r_start;
    logic [BLOCK_OFFSET_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_start <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_start <= i_start;
            // A transfer made in the load cycle itself already counts.
            r_cnt   <= i_inc ? BLOCK_OFFSET_W'(1) : '0;
        end else if (i_inc) begin
            r_cnt   <= r_cnt + BLOCK_OFFSET_W'(1);
        end
    end

    assign o_word = r_start + r_cnt;
    assign o_done = (r_cnt == BLOCK_OFFSET_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_sequencer.sv
// Arbitrates the single 4-cycle main memory between data-cache write-through
// stores, data-cache fills and instruction-cache fills. Fills are 8 pipelined
// word reads; returned words are steered into the granted cache's data array
// and the tag array is written with the last word.
//
// Build option: CRITICAL_WORD_FIRST_EN - when defined, a fill starts at the
// missing word (miss_addr[3:1]) and wraps around the block; otherwise every
// fill starts at word 0.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   icache_miss_detected/addr   - instruction-cache miss request
//   dcache_miss_detected/addr   - data-cache miss request
//   dcache_write_enable/addr/data - write-through store request
//   icache_fill_*/icache_write_*  - instruction-cache array write port
//   dcache_fill_*/dcache_write_*  - data-cache array write port
//   mainmem_*                   - main memory request and read-return port
//   stall_n                     - low while any request is pending or served
//
// state  | meaning
// IDLE   | waiting; grants write > dcache miss > icache miss, first fill read issued here
// WRITE  | single write-through store cycle to memory
// FILL_D | issuing/receiving an 8-word block for the data cache
// FILL_I | issuing/receiving an 8-word block for the instruction cache
module cache_fill_sequencer
    import cache_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss_detected,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss_detected,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              dcache_write_enable,
    input  logic [ADDR_W-1:0] dcache_write_addr,
    input  logic [DATA_W-1:0] dcache_write_data,
    output logic [DATA_W-1:0] icache_fill_data,
    output logic [ADDR_W-1:0] icache_fill_addr,
    output logic              icache_write_data_array,
    output logic              icache_write_tag_array,
    output logic [DATA_W-1:0] dcache_fill_data,
    output logic [ADDR_W-1:0] dcache_fill_addr,
    output logic              dcache_write_data_array,
    output logic              dcache_write_tag_array,
    output logic [ADDR_W-1:0] mainmem_addr,
    output logic [DATA_W-1:0] mainmem_write_data,
    output logic              mainmem_enable,
    output logic              mainmem_wr,
    input  logic [DATA_W-1:0] mainmem_read_data,
    input  logic              mainmem_data_valid,
    output logic              stall_n
);

    fill_state_t r_state;
    fill_state_t w_next_state;

    logic [ADDR_W-1:0]         r_base;
    logic                      r_ready;
    logic                      r_issue_active;

    logic                      w_load;
    logic                      w_issue_inc;
    logic                      w_recv_inc;
    logic [ADDR_W-1:0]         w_grant_addr;
    logic [ADDR_W-1:0]         w_recv_addr;
    logic [BLOCK_OFFSET_W-1:0] w_start;
    logic [BLOCK_OFFSET_W-1:0] w_issue_word;
    logic [BLOCK_OFFSET_W-1:0] w_recv_word;
    logic                      w_issue_done;
    logic                      w_recv_done;

    assign stall_n = (r_state == IDLE) &&
                     !(dcache_write_enable || dcache_miss_detected || icache_miss_detected);

    // Only meaningful in IDLE when a fill is granted; dcache wins over icache.
    assign w_grant_addr = dcache_miss_detected ? dcache_miss_addr : icache_miss_addr;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = w_grant_addr[3:1];
`else
    assign w_start = '0;
`endif

    assign w_recv_addr = block_word_addr(r_base, w_recv_word);

    fill_word_counter u_issue_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_start (w_start),
        .i_inc   (w_issue_inc),
        .o_word  (w_issue_word),
        .o_done  (w_issue_done)
    );

    fill_word_counter u_recv_cnt (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_start (w_start),
        .i_inc   (w_recv_inc),
        .o_word  (w_recv_word),
        .o_done  (w_recv_done)
    );

    // r_ready keeps the grant outputs quiet while rst is asserted (and for the
    // first edge after release) without feeding rst into combinational logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_base         <= '0;
            r_ready        <= 1'b0;
            r_issue_active <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= 1'b1;
            if (w_load) begin
                r_base         <= w_grant_addr & BLOCK_MASK;
                r_issue_active <= 1'b1;
            end else if (w_issue_inc && w_issue_done) begin
                r_issue_active <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state            = r_state;
        w_load                  = 1'b0;
        w_issue_inc             = 1'b0;
        w_recv_inc              = 1'b0;
        mainmem_enable          = 1'b0;
        mainmem_wr              = 1'b0;
        mainmem_addr            = '0;
        mainmem_write_data      = '0;
        icache_fill_data        = '0;
        icache_fill_addr        = '0;
        icache_write_data_array = 1'b0;
        icache_write_tag_array  = 1'b0;
        dcache_fill_data        = '0;
        dcache_fill_addr        = '0;
        dcache_write_data_array = 1'b0;
        dcache_write_tag_array  = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_ready) begin
                    if (dcache_write_enable) begin
                        w_next_state = WRITE;
                    end else if (dcache_miss_detected || icache_miss_detected) begin
                        w_next_state   = dcache_miss_detected ? FILL_D : FILL_I;
                        // The grant cycle already issues the first read.
                        w_load         = 1'b1;
                        w_issue_inc    = 1'b1;
                        mainmem_enable = 1'b1;
                        mainmem_addr   = block_word_addr(w_grant_addr, w_start);
                    end
                end
            end

            WRITE: begin
                mainmem_enable     = 1'b1;
                mainmem_wr         = 1'b1;
                mainmem_addr       = dcache_write_addr;
                mainmem_write_data = dcache_write_data;
                w_next_state       = IDLE;
            end

            FILL_D, FILL_I: begin
                if (r_issue_active) begin
                    mainmem_enable = 1'b1;
                    mainmem_addr   = block_word_addr(r_base, w_issue_word);
                    w_issue_inc    = 1'b1;
                end
                if (mainmem_data_valid) begin
                    w_recv_inc = 1'b1;
                    if (r_state == FILL_D) begin
                        dcache_fill_data        = mainmem_read_data;
                        dcache_fill_addr        = w_recv_addr;
                        dcache_write_data_array = 1'b1;
                        dcache_write_tag_array  = w_recv_done;
                    end else begin
                        icache_fill_data        = mainmem_read_data;
                        icache_fill_addr        = w_recv_addr;
                        icache_write_data_array = 1'b1;
                        icache_write_tag_array  = w_recv_done;
                    end
                    if (w_recv_done) begin
                        w_next_state = IDLE;
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Self-checking bench for cache_fill_sequencer: a 4-cycle memory model and a
// cache-side responder drive the DUT, and a transaction-level reference model
// builds the expected per-cycle outputs from the grant/fill timing rules.
module tb_cache_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss_detected;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss_detected;
    logic [15:0] dcache_miss_addr;
    logic        dcache_write_enable;
    logic [15:0] dcache_write_addr;
    logic [15:0] dcache_write_data;
    logic [15:0] icache_fill_data;
    logic [15:0] icache_fill_addr;
    logic        icache_write_data_array;
    logic        icache_write_tag_array;
    logic [15:0] dcache_fill_data;
    logic [15:0] dcache_fill_addr;
    logic        dcache_write_data_array;
    logic        dcache_write_tag_array;
    logic [15:0] mainmem_addr;
    logic [15:0] mainmem_write_data;
    logic        mainmem_enable;
    logic        mainmem_wr;
    logic [15:0] mainmem_read_data;
    logic        mainmem_data_valid;
    logic        stall_n;

    cache_fill_sequencer dut (
        .clk                     (clk),
        .rst                     (rst),
        .icache_miss_detected    (icache_miss_detected),
        .icache_miss_addr        (icache_miss_addr),
        .dcache_miss_detected    (dcache_miss_detected),
        .dcache_miss_addr        (dcache_miss_addr),
        .dcache_write_enable     (dcache_write_enable),
        .dcache_write_addr       (dcache_write_addr),
        .dcache_write_data       (dcache_write_data),
        .icache_fill_data        (icache_fill_data),
        .icache_fill_addr        (icache_fill_addr),
        .icache_write_data_array (icache_write_data_array),
        .icache_write_tag_array  (icache_write_tag_array),
        .dcache_fill_data        (dcache_fill_data),
        .dcache_fill_addr        (dcache_fill_addr),
        .dcache_write_data_array (dcache_write_data_array),
        .dcache_write_tag_array  (dcache_write_tag_array),
        .mainmem_addr            (mainmem_addr),
        .mainmem_write_data      (mainmem_write_data),
        .mainmem_enable          (mainmem_enable),
        .mainmem_wr              (mainmem_wr),
        .mainmem_read_data       (mainmem_read_data),
        .mainmem_data_valid      (mainmem_data_valid),
        .stall_n                 (stall_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] maddr;
        logic [15:0] mwdata;
        logic        iwe;
        logic        itag;
        logic [15:0] ifa;
        logic [15:0] ifd;
        logic        dwe;
        logic        dtag;
        logic [15:0] dfa;
        logic [15:0] dfd;
        logic        stall_n;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;

    exp_t        exp_q [int];
    rd_t         rd_q [$];
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Requested input values, applied just after the next rising edge.
    bit          sh_rst;
    bit          sh_imiss, sh_dmiss, sh_wen, sh_extra_valid;
    logic [15:0] sh_iaddr, sh_daddr, sh_waddr, sh_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expd);
        n_checks++;
        if (got !== expd) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, expd);
        end
    endtask

    function automatic exp_t get_exp(input int c);
        exp_t e;
        if (exp_q.exists(c)) return exp_q[c];
        e = '0;
        e.stall_n = 1'b1;
        return e;
    endfunction

    function automatic int start_word(input logic [15:0] a);
`ifdef CRITICAL_WORD_FIRST_EN
        return int'(a[3:1]);
`else
        return 0;
`endif
    endfunction

    // k-th word transferred for a miss at address a.
    function automatic logic [15:0] word_addr(input logic [15:0] a, input int k);
        return (a & 16'hFFF0) + 16'(2 * ((start_word(a) + k) % 8));
    endfunction

    task automatic plan_fill(input int g, input bit is_i, input logic [15:0] a);
        exp_t        e;
        logic [15:0] wa;
        for (int k = 0; k < 8; k++) begin
            e = get_exp(g + k);
            e.en = 1'b1;
            e.maddr = word_addr(a, k);
            exp_q[g + k] = e;
        end
        for (int k = 0; k < 8; k++) begin
            wa = word_addr(a, k);
            e = get_exp(g + 4 + k);
            if (is_i) begin
                e.iwe = 1'b1; e.ifa = wa; e.ifd = ref_mem[wa]; e.itag = (k == 7);
            end else begin
                e.dwe = 1'b1; e.dfa = wa; e.dfd = ref_mem[wa]; e.dtag = (k == 7);
            end
            exp_q[g + 4 + k] = e;
        end
    endtask

    // Requests all raised in cycle s are served write, dcache, icache in turn;
    // each is dropped by its requester once served.
    task automatic plan(input int s, input bit w, input bit d, input bit i, output int fin);
        exp_t e;
        int   g = s;
        if (w) begin
            e = get_exp(g + 1);
            e.en = 1'b1; e.wr = 1'b1; e.maddr = sh_waddr; e.mwdata = sh_wdata;
            exp_q[g + 1] = e;
            ref_mem[sh_waddr] = sh_wdata;
            g += 2;
        end
        if (d) begin plan_fill(g, 1'b0, sh_daddr); g += 12; end
        if (i) begin plan_fill(g, 1'b1, sh_iaddr); g += 12; end
        for (int c = s; c < g; c++) begin
            e = get_exp(c);
            e.stall_n = 1'b0;
            exp_q[c] = e;
        end
        fin = g;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        rst                  = sh_rst;
        icache_miss_detected = sh_imiss;
        icache_miss_addr     = sh_iaddr;
        dcache_miss_detected = sh_dmiss;
        dcache_miss_addr     = sh_daddr;
        dcache_write_enable  = sh_wen;
        dcache_write_addr    = sh_waddr;
        dcache_write_data    = sh_wdata;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            mainmem_data_valid = 1'b1;
            mainmem_read_data  = mem[rd_q[0].addr];
            void'(rd_q.pop_front());
        end else begin
            mainmem_data_valid = sh_extra_valid;
            mainmem_read_data  = 16'($urandom);
        end
        @(negedge clk);
        e = get_exp(cyc);
        check("mem",    {mainmem_enable, mainmem_wr, mainmem_addr, mainmem_write_data},
                        {e.en, e.wr, e.maddr, e.mwdata});
        check("icache", {icache_write_data_array, icache_write_tag_array, icache_fill_addr, icache_fill_data},
                        {e.iwe, e.itag, e.ifa, e.ifd});
        check("dcache", {dcache_write_data_array, dcache_write_tag_array, dcache_fill_addr, dcache_fill_data},
                        {e.dwe, e.dtag, e.dfa, e.dfd});
        check("stall_n", stall_n, e.stall_n);
        if (mainmem_enable && !mainmem_wr) rd_q.push_back('{cyc + 4, mainmem_addr});
        if (mainmem_enable && mainmem_wr) begin
            mem[mainmem_addr] = mainmem_write_data;
            sh_wen = 1'b0;
        end
        if (icache_write_tag_array) sh_imiss = 1'b0;
        if (dcache_write_tag_array) sh_dmiss = 1'b0;
    endtask

    task automatic run(input bit w, input bit d, input bit i, input logic [15:0] waddr,
                       input logic [15:0] wdata, input logic [15:0] daddr, input logic [15:0] iaddr);
        int s = cyc + 1;
        int fin;
        sh_wen = w; sh_dmiss = d; sh_imiss = i;
        sh_waddr = waddr; sh_wdata = wdata; sh_daddr = daddr; sh_iaddr = iaddr;
        plan(s, w, d, i, fin);
        repeat (3) step();
        // The first fill is granted by now; its miss address must no longer matter.
        if (d) sh_daddr = 16'($urandom);
        else if (i) sh_iaddr = 16'($urandom);
        repeat (fin - s - 1) step();
    endtask

    initial begin
        int s, fin;
        bit w, d, i;
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 16'($urandom);
            ref_mem[a] = mem[a];
        end
        rst = 1'b1;
        icache_miss_detected = 1'b0; icache_miss_addr = '0;
        dcache_miss_detected = 1'b0; dcache_miss_addr = '0;
        dcache_write_enable  = 1'b0; dcache_write_addr = '0; dcache_write_data = '0;
        mainmem_read_data = '0; mainmem_data_valid = 1'b0;
        sh_rst = 1'b1; sh_imiss = 0; sh_dmiss = 0; sh_wen = 0; sh_extra_valid = 0;
        sh_iaddr = '0; sh_daddr = '0; sh_waddr = '0; sh_wdata = '0;

        repeat (3) step();
        sh_rst = 1'b0;
        repeat (3) step();

        run(0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0124);
        run(0, 1, 1, 16'h0000, 16'h0000, 16'h2008, 16'h0040);
        run(1, 1, 0, 16'h1002, 16'hBEEF, 16'h3456, 16'h0000);

        // Reset in cycle 6 of a dcache fill; outstanding reads return while idle.
        s = cyc + 1;
        sh_dmiss = 1'b1; sh_daddr = 16'h4A5C;
        plan(s, 0, 1, 0, fin);
        repeat (6) step();
        for (int c = s + 6; c <= fin; c++) exp_q.delete(c);
        sh_rst = 1'b1; sh_dmiss = 1'b0;
        step();
        sh_rst = 1'b0;
        repeat (8) step();
        run(0, 1, 0, 16'h0000, 16'h0000, 16'h4A5C, 16'h0000);

        // Stray data_valid pulses while idle.
        sh_extra_valid = 1'b1;
        repeat (3) step();
        sh_extra_valid = 1'b0;
        step();

        run(0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0126);

        for (int n = 0; n < 20; n++) begin
            w = 1'($urandom); d = 1'($urandom); i = 1'($urandom);
            if (!(w || d || i)) i = 1'b1;
            run(w, d, i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) begin
                sh_extra_valid = 1'($urandom);
                step();
            end
            sh_extra_valid = 1'b0;
        end
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_sequencer.md
Name: cache_fill_sequencer

Overview:
- Shares the single 4-cycle main memory (memory4c) between the instruction cache, the data cache and data-cache write-through stores.
- Grants one requester at a time and issues pipelined 8-word block reads for cache fills.
- Steers the returned words into the granted cache's data array, then writes that cache's tag array.
- Holds the global pipeline stall (stall_n) low from request detection until the memory transaction completes.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block; the block is 16 bytes.
- MEM_LATENCY, 4: cycles from read issue (enable=1, wr=0) to mainmem_data_valid for that word.
- ADDR_W, 16: address width in bits.
- DATA_W, 16: data word width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- icache_miss_detected  in  1  instruction-cache read miss pending.
- icache_miss_addr  in  16  address of the instruction-cache miss.
- dcache_miss_detected  in  1  data-cache load miss pending.
- dcache_miss_addr  in  16  address of the data-cache miss.
- dcache_write_enable  in  1  store in MEM stage; write-through, no-write-allocate.
- dcache_write_addr  in  16  store address.
- dcache_write_data  in  16  store data.
- icache_fill_data  out  16  word being written into the instruction cache.
- icache_fill_addr  out  16  address of that word.
- icache_write_data_array  out  1  instruction-cache data-array write strobe.
- icache_write_tag_array  out  1  instruction-cache tag-array write strobe.
- dcache_fill_data  out  16  word being written into the data cache.
- dcache_fill_addr  out  16  address of that word.
- dcache_write_data_array  out  1  data-cache data-array write strobe.
- dcache_write_tag_array  out  1  data-cache tag-array write strobe.
- mainmem_addr  out  16  memory address.
- mainmem_write_data  out  16  memory write data.
- mainmem_enable  out  1  memory access enable.
- mainmem_wr  out  1  memory write (1) or read (0).
- mainmem_read_data  in  16  memory read data.
- mainmem_data_valid  in  1  mainmem_read_data is valid this cycle.
- stall_n  out  1  active-low global pipeline stall.

Behaviour:
- States: IDLE, WRITE, FILL_D, FILL_I. rst forces IDLE asynchronously, mid-operation included.
- On rst: issue and receive counters to 0, latched base to 0, all strobes/enables/addresses/data outputs to 0, outstanding fill abandoned.
- Grant priority in IDLE: dcache_write_enable, then dcache_miss_detected, then icache_miss_detected. The losing request remains asserted and is served after return to IDLE.
- stall_n is combinational: 1 only when state is IDLE and no request input is asserted, else 0. It therefore also reads 1 during reset if no request is present.
- WRITE: one cycle with mainmem_enable=1, mainmem_wr=1 and dcache_write_addr/dcache_write_data driven; next state IDLE.
- Fill grant: latch base = miss_addr & 16'hFFF0.
  - Issue: grant cycle is cycle 0. Cycles 0..7 drive mainmem_enable=1, mainmem_wr=0, mainmem_addr = base + 2*issue_cnt.
  - Receive: each mainmem_data_valid drives the granted cache's fill_data = mainmem_read_data, fill_addr = base + 2*recv_cnt and write_data_array=1, then increments recv_cnt.
  - Completion: the 8th valid word (recv_cnt==7) also asserts write_tag_array=1 in the same cycle. The next state is IDLE.
  - Nominal timing: data at cycles 4..11, IDLE at cycle 12, stall_n low for 12 cycles.
- mainmem_data_valid outside FILL_*, or after the 8th word, is ignored.
- Miss inputs are sampled only at grant. Changes during a fill are ignored.
- Address arithmetic is 16-bit. Word offsets wrap modulo 8 within the block; the base is never carried.
- Non-granted cache's fill strobes are always 0.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: issue and receive order start at word miss_addr[3:1] and wrap modulo 8. Offset k maps to address base + 2*((start+k) mod 8). The tag is written with the 8th returned word.
- Undefined: order always starts at word 0, as described in Behaviour.

Decomposition:
- Package cache_fill_pkg:
  - state enum fill_state_t {IDLE, WRITE, FILL_D, FILL_I};
  - WORDS_PER_BLOCK, BLOCK_OFFSET_W=3, BLOCK_MASK=16'hFFF0.
- Sub-module fill_word_counter: 3-bit counter with load-start, increment and done (8th count) output. Instantiated twice, for issue and receive.

Test Plan:
- icache_miss_detected with icache_miss_addr=0x0124 → mainmem_addr 0x0120..0x012E in cycles 0-7; icache_write_data_array in cycles 4-11 with fill_addr matching; icache_write_tag_array in cycle 11 only; stall_n=0 for 12 cycles.
- icache and dcache misses asserted in the same cycle (0x0040 and 0x2008) → dcache fill of 0x2000 block completes first, then icache fill of 0x0040 block; no overlap of mainmem_enable between fills.
- dcache_write_enable with addr 0x1002, data 0xBEEF, together with dcache_miss → one WRITE cycle (enable=1, wr=1, addr 0x1002, data 0xBEEF) precedes the fill.
- rst pulsed at cycle 6 of a dcache fill → all outputs 0 immediately; late data_valid pulses ignored; new miss restarts at word 0.
- With CRITICAL_WORD_FIRST_EN, miss 0x0126 → issue order 0x0126, 0x0128, 0x012A, 0x012C, 0x012E, 0x0120, 0x0122, 0x0124; tag strobe with the 0x0124 word.
- Extra mainmem_data_valid pulse in IDLE → no cache strobe asserted; stall_n stays 1.
